// File: rtl/ysyx_ifu.sv
// Instruction fetch unit for the multi-cycle ysyx RV32 core: fetches one word per
// instruction over a valid/ready port, holds it for decode, then waits for the next PC.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        inst_ready,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_RESP  = 3'd1,
        S_HOLD  = 3'd2,
        S_WAIT  = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        fault_q, fault_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        inst_valid_q, inst_valid_d;

    // Next-state and datapath updates; handshake flags are decoded from the next state
    // so that they register alongside it and never depend on same-cycle inputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        fetch_cnt_d = fetch_cnt_q;
        fault_d     = fault_q;
        case (state_q)
            S_REQ: begin
                if (arvalid_q && imem_arready) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_RESP: begin
                if (imem_rvalid) begin
                    if (imem_rresp == 2'b00) begin
                        inst_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_WAIT;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_WAIT: begin
                if (commit_valid) begin
                    if (commit_pc[1:0] == 2'b00) begin
                        pc_d    = commit_pc;
                        state_d = S_REQ;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                // A corrupted state encoding is treated as a fault rather than guessed at.
                fault_d = 1'b1;
                state_d = S_FAULT;
            end
        endcase
        arvalid_d    = (state_d == S_REQ);
        rready_d     = (state_d == S_RESP);
        inst_valid_d = (state_d == S_HOLD);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0013;
            fetch_cnt_q  <= 32'd0;
            fault_q      <= 1'b0;
            arvalid_q    <= 1'b1;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            fetch_cnt_q  <= fetch_cnt_d;
            fault_q      <= fault_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign imem_arvalid = arvalid_q;
    assign imem_araddr  = pc_q;
    assign imem_rready  = rready_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign pc           = pc_q;
    assign fetch_fault  = fault_q;
    assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_ifu.sv
// Self-checking bench for ysyx_ifu: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_ysyx_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_arvalid, imem_rready, inst_valid, fetch_fault;
    logic [31:0] imem_araddr, inst, pc, fetch_cnt;
    logic        imem_arready = 1'b0, imem_rvalid = 1'b0, inst_ready = 1'b0, commit_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0, commit_pc = 32'd0;
    logic [1:0]  imem_rresp = 2'b00;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    ysyx_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(imem_arready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
        .imem_rready(imem_rready), .inst_valid(inst_valid), .inst(inst), .pc(pc),
        .inst_ready(inst_ready), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .fetch_fault(fetch_fault), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what the fetch is currently waiting for, plus architectural values.
    localparam int AWAIT_ADDR_ACCEPT = 0;
    localparam int AWAIT_DATA        = 1;
    localparam int AWAIT_CONSUME     = 2;
    localparam int AWAIT_COMMIT      = 3;
    localparam int DEAD              = 4;

    int          m_wait  = AWAIT_ADDR_ACCEPT;
    logic [31:0] m_pc    = 32'h8000_0000;
    logic [31:0] m_inst  = 32'h0000_0013;
    logic [31:0] m_cnt   = 32'd0;
    logic        m_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [131:0] got, want;
        got  = {imem_arvalid, imem_rready, inst_valid, imem_araddr, inst, pc, fetch_fault, fetch_cnt};
        want = {m_wait == AWAIT_ADDR_ACCEPT, m_wait == AWAIT_DATA, m_wait == AWAIT_CONSUME,
                m_pc, m_inst, m_pc, m_fault, m_cnt};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL cycle%0d {arv,rrdy,ivld,addr,inst,pc,fault,cnt}: got %h want %h", cyc, got, want);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock the DUT, compare on the falling edge.
    task automatic step(input bit r, input bit ar, input bit rv, input logic [31:0] rd,
                        input logic [1:0] rr, input bit ir, input bit cv, input logic [31:0] cpc);
        rst = r; imem_arready = ar; imem_rvalid = rv; imem_rdata = rd; imem_rresp = rr;
        inst_ready = ir; commit_valid = cv; commit_pc = cpc;
        if (r) begin
            m_wait = AWAIT_ADDR_ACCEPT; m_pc = 32'h8000_0000; m_inst = 32'h0000_0013;
            m_fault = 1'b0; m_cnt = 32'd0;
        end else begin
            case (m_wait)
                AWAIT_ADDR_ACCEPT: if (ar) m_wait = AWAIT_DATA;
                AWAIT_DATA: if (rv) begin
                    if (rr == 2'b00) begin m_inst = rd; m_wait = AWAIT_CONSUME; end
                    else begin m_fault = 1'b1; m_wait = DEAD; end
                end
                AWAIT_CONSUME: if (ir) begin m_cnt = m_cnt + 32'd1; m_wait = AWAIT_COMMIT; end
                AWAIT_COMMIT: if (cv) begin
                    if (cpc % 4 == 0) begin m_pc = cpc; m_wait = AWAIT_ADDR_ACCEPT; end
                    else begin m_fault = 1'b1; m_wait = DEAD; end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          dead_cycles;
        @(negedge clk);

        // Reset and one complete best-case fetch.
        step(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("reset_araddr", imem_araddr, 32'h8000_0000);
        chk("reset_arvalid", {31'd0, imem_arvalid}, 32'd1);
        chk("reset_inst", inst, 32'h0000_0013);
        chk("reset_cnt", fetch_cnt, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("resp_rready", {31'd0, imem_rready}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0010_0093, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("t2_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t2_inst", inst, 32'h0010_0093);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
        chk("cnt_after_consume", fetch_cnt, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0004);
        chk("second_araddr", imem_araddr, 32'h8000_0004);

        // Address stall: request stays stable until accepted.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b1, 1'b1, 32'h0000_0040);
            chk("stall_arvalid", {31'd0, imem_arvalid}, 32'd1);
            chk("stall_araddr", imem_araddr, 32'h8000_0004);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("accepted_arvalid", {31'd0, imem_arvalid}, 32'd0);

        // HOLD with inst_ready low and a stray commit.
        step(1'b0, 1'b0, 1'b1, 32'h00A0_0513, 2'b00, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, (i == 1), 32'h8000_0100);
            chk("hold_inst", inst, 32'h00A0_0513);
            chk("hold_pc", pc, 32'h8000_0004);
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
        chk("hold_cnt", fetch_cnt, 32'd2);

        // Jump, then misaligned target.
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0100);
        chk("jump_araddr", imem_araddr, 32'h8000_0100);
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_006F, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0102);
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misalign_pc", pc, 32'h8000_0100);
        step(1'b0, 1'b1, 1'b1, 32'd0, 2'b00, 1'b1, 1'b1, 32'h8000_0200);
        chk("misalign_no_arvalid", {31'd0, imem_arvalid}, 32'd0);

        // Bad response: terminal until reset.
        step(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 32'd0);
        chk("rresp_fault", {31'd0, fetch_fault}, 32'd1);
        chk("rresp_inst", inst, 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 32'h1111_1111, 2'b00, 1'b1, 1'b1, 32'h8000_0008);
            chk("fault_no_ivalid", {31'd0, inst_valid}, 32'd0);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("rst_clears_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_pc", pc, 32'h8000_0000);
        chk("rst_arvalid", {31'd0, imem_arvalid}, 32'd1);

        // Counter wrap from a preloaded all-ones value.
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        idle(1);
        release dut.fetch_cnt_q;
        idle(1);
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0033, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, 32'd0);
        chk("cnt_wrap", fetch_cnt, 32'd0);

        // Reset while waiting for read data.
        step(1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 1'b1, 32'h8000_0004);
        step(1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h7777_7777, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("rst_in_resp_arvalid", {31'd0, imem_arvalid}, 32'd1);
        chk("rst_in_resp_inst", inst, 32'h0000_0013);

        // Randomized traffic against the model.
        dead_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] cpc;
            logic [1:0]  rr;
            bit          r;
            int          sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      cpc = m_pc + 32'd4;
            else if (sel < 95) cpc = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            else               cpc = m_pc + 32'd4 + 32'($urandom_range(1, 3));
            rr = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            dead_cycles = (m_wait == DEAD) ? dead_cycles + 1 : 0;
            r = ($urandom_range(0, 199) == 0) || (dead_cycles > 4);
            w = $urandom();
            step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, rr,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cpc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
